// File: rtl/count_job_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_job_pkg
// Description : Shared definitions for the count-job arbiter: the FSM state
//               encoding and its width.
// Revision    : 1.0 - initial release
// ============================================================================
package count_job_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/count_job_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : count_job_arbiter_if
// Description : Request/grant bundle between the requesters (master side)
//               and the count-job arbiter (slave side).
// Signals     : req    - level request per requester
//               limit  - terminal count per requester, CNT_W bits each
//               grant  - one-hot owner, zero when idle
//               busy   - a job is counting or completing
//               count  - current shared count value
//               done   - one-cycle completion pulse to the owner
// Revision    : 1.0 - initial release
// ============================================================================
interface count_job_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] limit;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         count;
  logic [NUM_REQ-1:0]       done;

  modport master (
    output req,
    output limit,
    input  grant,
    input  busy,
    input  count,
    input  done
  );

  modport slave (
    input  req,
    input  limit,
    output grant,
    output busy,
    output count,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/count_job_arbiter_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider producing a one-cycle tick enable every
//               TICK_DIV clk cycles. clr restarts the period so the first
//               tick lands TICK_DIV cycles after clr.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               clr  - synchronous restart of the divider
//               tick - high while the divider sits at TICK_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int TICK_DIV = 1500000,
  parameter int DIV_W    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (clr || (tick_cnt == LAST)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/count_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : count_job_arbiter
// Description : Shares one tick-driven up-counter among NUM_REQ requesters.
//               A round-robin pick hands the counter to one requester, which
//               owns it until the count reaches its latched limit; a
//               one-cycle done pulse is then returned to that requester.
//               All outputs are registered.
// Ports       : clk - system clock
//               rst - asynchronous active-high reset
//               bus - count_job_arbiter_if.slave (req, limit, grant, busy,
//                     count, done)
// Options     : COUNT_JOB_ABORT_EN - when defined, the owner dropping its
//               req during counting abandons the job without a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module count_job_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CNT_W    = 4,
  parameter int TICK_DIV = 1500000,
  parameter int DIV_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  count_job_arbiter_if.slave   bus
);

  import count_job_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;
  logic [CNT_W-1:0]   count_q;
  logic [NUM_REQ-1:0] done_q;
  logic [CNT_W-1:0]   lim_q;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   owner_next;
  logic [IDX_W-1:0]   rr_ptr;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               tick;
  logic               start;

  // Round-robin pick: scan downward so the last hit, i.e. the first set bit
  // at or above rr_ptr (wrapping), is the one that sticks.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Restarting the divider on the grant edge makes the first COUNT cycle see
  // tick_cnt==0, so every count step is a full TICK_DIV period.
  assign start = (state == ST_IDLE) && pick_valid;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      done_q  <= '0;
      lim_q   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state   <= ST_COUNT;
            grant_q <= NUM_REQ'(1) << pick_idx;
            busy_q  <= 1'b1;
            count_q <= '0;
            lim_q   <= bus.limit[int'(pick_idx)*CNT_W +: CNT_W];
            owner   <= pick_idx;
          end
        end

        ST_COUNT: begin
`ifdef COUNT_JOB_ABORT_EN
          if (!bus.req[owner]) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            rr_ptr  <= owner_next;
          end else
`endif
          if (tick) begin
            if (count_q == lim_q) begin
              state  <= ST_DONE;
              done_q <= grant_q;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
          rr_ptr  <= owner_next;
        end

        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: doc/count_job_arbiter.md
Name: count_job_arbiter

Overview:
- Shares one tick-driven up-counter among NUM_REQ requesters, each with its own terminal count.
- Round-robin arbitration picks one requester. It owns the counter until its count reaches its limit. A one-cycle done pulse then goes back to that requester.
- Sits between user-facing button/control logic and the LED counter datapath.
- Replaces derived-clock counting: everything runs on clk, advanced by an internal tick enable.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- CNT_W, 4, counter and limit width.
- TICK_DIV, 1500000, clk cycles per count tick (≥2).
- DIV_W, 24, tick divider width; must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held until done or abort.
- limit  in  NUM_REQ*CNT_W  terminal count per requester; slice i = limit[i*CNT_W +: CNT_W].
- grant  out  NUM_REQ  one-hot owner; all-zero when idle.
- busy  out  1  high in COUNT and DONE.
- count  out  CNT_W  current shared count value.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.

Behaviour:
- Reset (async): state=IDLE, grant=0, busy=0, count=0, done=0, tick_cnt=0, rr_ptr=0 (index 0 highest priority).
- All outputs are registered (Moore); no combinational path from req to outputs.
- Tick generation:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 when tick_cnt==TICK_DIV-1.
  - tick_cnt is forced to 0 on the cycle COUNT is entered, so the first tick falls in the TICK_DIV-th cycle of COUNT.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr, wrapping.
  - Next cycle: grant=onehot(owner), busy=1, count=0, limit[owner] latched into lim_q, state=COUNT.
  - Latency req→grant is 1 cycle.
- COUNT, on each tick:
  - If count==lim_q, go to DONE.
  - Otherwise count<=count+1.
  - count never wraps; lim_q ≤ 2^CNT_W-1 bounds it.
- DONE:
  - Lasts exactly 1 cycle; done[owner]=1, grant held, count holds lim_q.
  - Then state=IDLE, grant=0, busy=0, count=0, rr_ptr=(owner+1) mod NUM_REQ.
- Job duration: limit L occupies COUNT for (L+1)*TICK_DIV cycles, plus 1 cycle of DONE.
- Boundary cases:
  - limit=0: DONE on the first tick; count stays 0.
  - limit changes while owned: ignored (lim_q is latched).
  - req of a non-owner while busy: ignored, no queueing beyond the level req; arbitrated in the next IDLE.
  - Owner still requesting after done: eligible again, but rr_ptr has moved past it, so other pending requesters win first.
  - IDLE always lasts at least 1 cycle between jobs.
  - Illegal state encoding: go to IDLE, outputs cleared.
  - rst mid-job: immediate return to reset values, no done pulse.

Optional Feature:
- Macro: COUNT_JOB_ABORT_EN.
- Defined: if req[owner]==0 during COUNT, next cycle is IDLE with grant=0, count=0, no done pulse, and rr_ptr=(owner+1) mod NUM_REQ.
- Undefined: req[owner] is ignored after grant; the job always runs to DONE.

Decomposition:
- Package count_job_pkg: state encoding (ST_IDLE=2'd0, ST_COUNT=2'd1, ST_DONE=2'd2), state width constant.
- Sub-module tick_gen: parameters TICK_DIV and DIV_W; inputs clk, rst, clr; output tick.
- Round-robin pick stays in the top level.

Test Plan (TICK_DIV=4, NUM_REQ=4, CNT_W=4):
- Reset asserted with req=4'b1111 → grant=0, busy=0, count=0, done=0 throughout reset; after release, grant=4'b0001 one cycle later.
- req[2]=1, limit[2]=3 → grant=4'b0100 next cycle; count steps 0→1→2→3 every 4 cycles; done=4'b0100 for exactly 1 cycle, 17 cycles after grant; then grant=0, count=0.
- req[0] and req[3] held high, limits=1 → grants in order 0001, 1000, 0001, each job 8+1 cycles, with ≥1 IDLE cycle between grants.
- limit[1]=0 → done[1] pulses exactly 5 cycles after grant (4 COUNT + 1 DONE); count stays 0.
- rst pulsed while count=2 → all outputs 0 immediately (async); no done pulse; next arbitration starts from index 0.
- req[1] dropped while count=1:
  - with COUNT_JOB_ABORT_EN: IDLE next cycle, no done.
  - without it: job completes and done[1] pulses.
